// File: rtl/alu_pipe_flags_if.sv
// alu_pipe_flags_if: request/result bundle for alu_pipe_flags.
// The master issues operations and consumes results; the slave is the ALU.
interface alu_pipe_flags_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [3:0]            opcode;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero_flag;
  logic                  carry_flag;
  logic                  negative_flag;
  logic                  overflow_flag;
  logic                  illegal_op;
  logic                  sticky_ovf;
  logic                  clr_sticky;

  modport master (
    output in_valid, A, B, opcode, out_ready, clr_sticky,
    input  in_ready, out_valid, result, zero_flag, carry_flag, negative_flag,
           overflow_flag, illegal_op, sticky_ovf
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready, clr_sticky,
    output in_ready, out_valid, result, zero_flag, carry_flag, negative_flag,
           overflow_flag, illegal_op, sticky_ovf
  );
endinterface

// File: rtl/alu_pipe_flags.sv
// alu_pipe_flags: registered valid/ready ALU with flags, stored carry for ADC/SBB chains and
// sticky overflow. Define ALU_MUL_EN to add the iterative shift-add multiplier (opcode 1100).
module alu_pipe_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int SHW        = $clog2(DATA_WIDTH)
) (
  input logic             clk,
  input logic             rst,
  alu_pipe_flags_if.slave bus
);
  localparam int W = DATA_WIDTH;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_SRA = 4'h8;
  localparam logic [3:0] OP_ADC = 4'h9;
  localparam logic [3:0] OP_SBB = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;

  logic           cst;
  logic           out_free;
  logic           accept;
  logic           idle;
  logic           load_alu;
  logic [SHW-1:0] shamt;
  logic           cin;
  logic [W:0]     sum_ext;
  logic [W:0]     dif_ext;
  logic [W:0]     shl_ext;
  logic [W:0]     shr_ext;
  logic [W:0]     sra_ext;
  logic [W-1:0]   c_res;
  logic [W-1:0]   flag_src;
  logic           c_carry;
  logic           c_ovf;
  logic           c_zero;
  logic           c_neg;
  logic           c_ill;
  logic           c_upd_cst;
  logic           c_is_mul;

  assign out_free     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !rst && idle && out_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign load_alu     = accept && !c_is_mul;

  // Shifts run one bit wider so the last bit shifted out lands in a fixed position.
  always_comb begin
    shamt   = bus.B[SHW-1:0];
    cin     = ((bus.opcode == OP_ADC) || (bus.opcode == OP_SBB)) && cst;
    sum_ext = {1'b0, bus.A} + {1'b0, bus.B} + {{W{1'b0}}, cin};
    dif_ext = {1'b0, bus.A} - {1'b0, bus.B} - {{W{1'b0}}, cin};
    shl_ext = {1'b0, bus.A} << shamt;
    shr_ext = {bus.A, 1'b0} >> shamt;
    sra_ext = $signed({bus.A, 1'b0}) >>> shamt;

    c_res     = '0;
    c_carry   = 1'b0;
    c_ovf     = 1'b0;
    c_ill     = 1'b0;
    c_upd_cst = 1'b0;
    c_is_mul  = 1'b0;
    case (bus.opcode)
      OP_ADD, OP_ADC: begin
        c_res     = sum_ext[W-1:0];
        c_carry   = sum_ext[W];
        c_ovf     = (bus.A[W-1] == bus.B[W-1]) && (sum_ext[W-1] != bus.A[W-1]);
        c_upd_cst = 1'b1;
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        c_res     = dif_ext[W-1:0];
        c_carry   = dif_ext[W];
        c_ovf     = (bus.A[W-1] != bus.B[W-1]) && (dif_ext[W-1] != bus.A[W-1]);
        c_upd_cst = 1'b1;
      end
      OP_AND: c_res = bus.A & bus.B;
      OP_OR:  c_res = bus.A | bus.B;
      OP_XOR: c_res = bus.A ^ bus.B;
      OP_NOT: c_res = ~bus.A;
      OP_SHL: begin
        c_res     = shl_ext[W-1:0];
        c_carry   = shl_ext[W];
        c_upd_cst = 1'b1;
      end
      OP_SHR: begin
        c_res     = shr_ext[W:1];
        c_carry   = shr_ext[0];
        c_upd_cst = 1'b1;
      end
      OP_SRA: begin
        c_res     = sra_ext[W:1];
        c_carry   = sra_ext[0];
        c_upd_cst = 1'b1;
      end
`ifdef ALU_MUL_EN
      4'hC: c_is_mul = 1'b1;
`endif
      default: c_ill = 1'b1;
    endcase

    // CMP reports flags of the difference but passes A through as the result.
    flag_src = c_res;
    if (bus.opcode == OP_CMP) c_res = bus.A;
    c_zero = !c_ill && (flag_src == '0);
    c_neg  = !c_ill && flag_src[W-1];
  end

`ifdef ALU_MUL_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]     state;
  logic [2*W-1:0] m_cand;
  logic [2*W-1:0] m_acc;
  logic [2*W-1:0] m_acc_next;
  logic [2*W-1:0] m_prod;
  logic [W-1:0]   m_plier;
  logic [SHW-1:0] m_cnt;
  logic           m_last;
  logic           mul_load;

  // The final partial product is folded in on the same edge that loads the output.
  always_comb begin
    m_acc_next = m_acc + (m_plier[0] ? m_cand : '0);
    m_last     = (m_cnt == SHW'(W - 1));
    m_prod     = (state == ST_HOLD) ? m_acc : m_acc_next;
    mul_load   = out_free && (((state == ST_MUL) && m_last) || (state == ST_HOLD));
    idle       = (state == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      m_cand  <= '0;
      m_acc   <= '0;
      m_plier <= '0;
      m_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && c_is_mul) begin
            state   <= ST_MUL;
            m_cand  <= {{W{1'b0}}, bus.A};
            m_plier <= bus.B;
            m_acc   <= '0;
            m_cnt   <= '0;
          end
        end
        ST_MUL: begin
          m_acc   <= m_acc_next;
          m_cand  <= m_cand << 1;
          m_plier <= m_plier >> 1;
          m_cnt   <= m_cnt + 1'b1;
          if (m_last) state <= out_free ? ST_IDLE : ST_HOLD;
        end
        ST_HOLD: begin
          if (out_free) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  assign idle = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid     <= 1'b0;
      bus.result        <= '0;
      bus.zero_flag     <= 1'b0;
      bus.carry_flag    <= 1'b0;
      bus.negative_flag <= 1'b0;
      bus.overflow_flag <= 1'b0;
      bus.illegal_op    <= 1'b0;
      bus.sticky_ovf    <= 1'b0;
      cst               <= 1'b0;
    end else begin
      if (load_alu) begin
        bus.out_valid     <= 1'b1;
        bus.result        <= c_res;
        bus.zero_flag     <= c_zero;
        bus.carry_flag    <= c_carry;
        bus.negative_flag <= c_neg;
        bus.overflow_flag <= c_ovf;
        bus.illegal_op    <= c_ill;
      end
`ifdef ALU_MUL_EN
      else if (mul_load) begin
        bus.out_valid     <= 1'b1;
        bus.result        <= m_prod[W-1:0];
        bus.zero_flag     <= (m_prod[W-1:0] == '0);
        bus.carry_flag    <= |m_prod[2*W-1:W];
        bus.negative_flag <= m_prod[W-1];
        bus.overflow_flag <= 1'b0;
        bus.illegal_op    <= 1'b0;
      end
`endif
      else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (load_alu && c_upd_cst) cst <= c_carry;

      if (load_alu && c_ovf)   bus.sticky_ovf <= 1'b1;
      else if (bus.clr_sticky) bus.sticky_ovf <= 1'b0;
    end
  end
endmodule

// File: doc/alu_pipe_flags.md
# alu_pipe_flags

Registered, handshaked ALU with flags: the parametrised successor to the team's combinational flag ALU. Adds valid/ready flow control, a stored carry for multi-word ADC/SBB chains, barrel shifts by operand amount, a sticky overflow status bit and an optional iterative multiplier. It sits between the instruction-issue stage and the register writeback/status logic.

## Interface
- DATA_WIDTH, 8, operand/result width; must be ≥4 and a power of two.
- SHW, $clog2(DATA_WIDTH), shift-amount width taken from B[SHW-1:0].
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request this cycle.
- A, B  in  DATA_WIDTH  operands.
- opcode  in  4  operation select.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  DATA_WIDTH  registered result.
- zero_flag, carry_flag, negative_flag, overflow_flag  out  1 each  registered flags for result.
- illegal_op  out  1  result came from an unsupported opcode.
- sticky_ovf  out  1  set by any completed op with overflow_flag=1.
- clr_sticky  in  1  clears sticky_ovf.

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT A, 0110 SHL A by B[SHW-1:0], 0111 SHR logical, 1000 SRA, 1001 ADC (A+B+Cst), 1010 SBB (A−B−Cst), 1011 CMP (computes A−B for flags; result=A), 1100 MUL (only with macro). All others are illegal.
- Arithmetic is computed in DATA_WIDTH+1 bits. ADD/ADC: carry=bit DATA_WIDTH. SUB/SBB/CMP: carry=borrow (1 when unsigned A < B+borrow-in). Overflow is signed overflow for add/sub classes and 0 for all others.
- Shifts: carry=last bit shifted out; shift amount 0 gives carry 0 and result A. Logic ops and NOT: carry=0.
- zero_flag=(result==0); negative_flag=result MSB; for CMP both are derived from the difference, not from result.
- Cst (internal stored carry) takes the carry_flag of every completed ADD/SUB/ADC/SBB/CMP/shift. It is unchanged by logic, MUL and illegal ops.
- Illegal opcode: result 0, all four flags 0, illegal_op=1, Cst and sticky_ovf unchanged.
- sticky_ovf is set when a result with overflow_flag=1 is loaded into the output register. clr_sticky clears it. If set and clear occur in the same cycle, set wins.
- FSM states: IDLE, MUL, HOLD.
  - IDLE: a single-cycle op is accepted and its result loads the output register directly.
  - A MUL accept moves to MUL.
  - MUL runs a shift-add over DATA_WIDTH cycles, then loads the output (moving to HOLD if the output register is still occupied) and returns to IDLE.

## Timing
- Reset: result=0, all flags 0, illegal_op=0, sticky_ovf=0, out_valid=0, Cst=0, FSM=IDLE. in_ready=0 while rst=1.
- Handshake: a transfer occurs when valid&&ready. Inputs are sampled only on accept. Outputs hold stable while out_valid && !out_ready.
- in_ready = (FSM==IDLE) && (!out_valid || out_ready). This allows one-per-cycle throughput, with ready passing through combinationally from out_ready.
- Single-cycle ops: accept at cycle t → out_valid at t+1.
- MUL: accept at t → out_valid at t+DATA_WIDTH+1. in_ready stays 0 throughout.
- ADC/SBB accepted at t+1 use the Cst produced by the op accepted at t (back-to-back chaining is required).
- rst asserted mid-MUL aborts the operation; no result is produced.

## Configuration
- ALU_MUL_EN defined: opcode 1100 is the unsigned multiply.
  - result = low half of A*B.
  - carry_flag = (high half ≠ 0).
  - overflow_flag = 0.
  - Zero and negative flags follow the usual rules.
- ALU_MUL_EN undefined: the MUL state and datapath are absent, and 1100 is illegal (single-cycle, illegal_op=1).

## Test plan
- ADD A=0xFF, B=0x01 → next cycle result=0x00, Z=1, C=1, N=0, V=0. Then ADC A=0x00, B=0x00 back-to-back → result=0x01, C=0.
- SUB A=0x80, B=0x01 → result=0x7F, V=1, C=0, sticky_ovf=1. Then clr_sticky and an overflowing ADD in the same cycle → sticky_ovf stays 1.
- SRA A=0x90, B=0x03 → result=0xF2, C=0, N=1. SHL A=0x81, B=0x00 → result=0x81, C=0.
- Backpressure: out_ready=0 with two queued requests → first result held stable, in_ready=0, second request accepted only in the cycle out_ready=1.
- MUL (ALU_MUL_EN) A=0x10, B=0x11 → result=0x10, C=1, out_valid exactly 9 cycles after accept. Assert rst mid-MUL → out_valid never rises.
- opcode 0xF with A=0x55 → result=0x00, illegal_op=1, flags 0, Cst preserved (verified by a following ADC).
